bcd_seq_converter: RTL and testbench



---
 rtl/bcd_pkg.sv | 27 ++
 rtl/dabble_digit.sv | 16 +
 rtl/bcd_seq_converter.sv | 127 ++++++++++++
 tb/tb_bcd_seq_converter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// seven_seg display path: display codes and the converter state encoding.
package bcd_pkg;

  // Seven-segment codes shared with the seven_seg digit decoders.
  localparam logic [3:0] SEG_OFF = 4'hA;  // blank digit
  localparam logic [3:0] SEG_NEG = 4'hB;  // minus sign

  // Converter state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // 10**n as a wide value, used to confirm at elaboration that DIGITS
  // decimal digits can hold the largest magnitude of a DATA_W sample.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/dabble_digit.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added
// before the shift, so that the shift carries correctly into the next digit.
module dabble_digit (
  input  logic [3:0] bcd_in,
  output logic [3:0] bcd_out
);

  // Add-3 correction applied ahead of every left shift.
  always_comb begin
    bcd_out = bcd_in;
    if (bcd_in >= 4'd5) begin
      bcd_out = bcd_in + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-add-3 (double-dabble) converter. Takes a two's-complement
// sample, converts its magnitude one bit per clock and presents registered
// BCD digits plus a sign-digit code for the seven_seg decoders.
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, zero digits
// above the most significant nonzero digit are shown blank (digit 0 never).
//
// Handshake: a sample is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE with rst_n high; an
// in_valid seen while in_ready is low is ignored and nothing is queued.
// out_valid is a one-cycle pulse marking the cycle digits/sign_code change.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            sign_code,
  output logic                  out_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

  // The magnitude can reach 2**(DATA_W-1) (most negative input), so the
  // digit count must cover that value.
  if (pow10(DIGITS) - 1 < (longint'(1) << (DATA_W - 1))) begin : g_range_check
    $error("bcd_seq_converter: DIGITS too small for DATA_W");
  end

  conv_state_t         state;
  logic                sign_q;
  logic [DATA_W-1:0]   mag_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   in_mag;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    disp_digits;
  logic                accept;

  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;

  // |in_data| fits in DATA_W unsigned bits, including -2**(DATA_W-1).
  assign in_mag = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

  // One add-3 cell per BCD digit, applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    dabble_digit u_cell (
      .bcd_in  (bcd_q[4*g +: 4]),
      .bcd_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_seen;

  // Blank zero digits above the most significant nonzero one; keep digit 0.
  always_comb begin
    disp_digits = bcd_q;
    lead_seen   = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!lead_seen && (bcd_q[4*i +: 4] == 4'd0)) begin
        disp_digits[4*i +: 4] = SEG_OFF;
      end else begin
        lead_seen = 1'b1;
      end
    end
  end
`else
  assign disp_digits = bcd_q;
`endif

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      digits    <= {DIGITS{SEG_OFF}};
      sign_code <= SEG_OFF;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= in_data[DATA_W-1];
            mag_q  <= in_mag;
            bcd_q  <= '0;
            cnt_q  <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // {bcd, mag} shifted left by one after the add-3 correction.
          bcd_q <= {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
          mag_q <= {mag_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state <= DONE;
          end
        end
        DONE: begin
          digits    <= disp_digits;
          // Minus only for a negative sample with nonzero magnitude.
          sign_code <= (sign_q && (|bcd_q)) ? SEG_NEG : SEG_OFF;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter (DATA_W=8, DIGITS=3). Expected
// digits are hand-computed; both raw and blanked forms are listed so the
// bench follows the LEADING_ZERO_BLANK_EN build of the design.
module tb_bcd_seq_converter;

  localparam int DATA_W = 8;
  localparam int DIGITS = 3;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] digits;
  logic [3:0]          sign_code;
  logic                out_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cycle);
    $fatal(1, "watchdog expired");
  end

  bcd_seq_converter #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .digits    (digits),
    .sign_code (sign_code),
    .out_valid (out_valid)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];      // {sign_code, digits}
  int          exp_cyc_q[$];  // cycle at which out_valid must be seen
  int          ov_cycles[$];

  always @(negedge clk) begin
    logic [15:0] e;
    int          c;
    if (out_valid === 1'b1) begin
      ov_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("digits", 32'(digits), 32'(e[11:0]));
        check("sign_code", 32'(sign_code), 32'(e[15:12]));
        check("latency", 32'(cycle), 32'(c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one sample and wait (bounded) for it to be accepted. Called at a
  // negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [11:0] raw,
                      input logic [11:0] blk, input logic [3:0] sgn,
                      input bit expect_out);
    int          waited;
    logic [11:0] dexp;
`ifdef LEADING_ZERO_BLANK_EN
    dexp = blk;
`else
    dexp = raw;
`endif
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else if (expect_out) begin
      exp_q.push_back({sgn, dexp});
      // Accept edge is cycle+1; out_valid is seen after edge accept+DATA_W+1.
      exp_cyc_q.push_back(cycle + DATA_W + 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_ov;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_digits", 32'(digits), 32'h0AAA);
    check("reset_sign", 32'(sign_code), 32'hA);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic values including zero and both range limits.
    send(8'd0,   12'h000, 12'hAA0, 4'hA, 1'b1);
    drain();
    send(8'd127, 12'h127, 12'h127, 4'hA, 1'b1);
    send(8'h80,  12'h128, 12'h128, 4'hB, 1'b1);
    send(8'hF6,  12'h010, 12'hA10, 4'hB, 1'b1);
    drain();

    // Sample offered during SHIFT is ignored.
    send(8'd42, 12'h042, 12'hA42, 4'hA, 1'b1);
    in_data  = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    check("ready_back_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of a conversion aborts it.
    send(8'd77, 12'h077, 12'hA77, 4'hA, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("abort_digits", 32'(digits), 32'h0AAA);
    check("abort_sign", 32'(sign_code), 32'hA);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clk);
    send(8'd99, 12'h099, 12'hA99, 4'hA, 1'b1);
    drain();

    // Back-to-back with in_valid held high.
    n_ov = ov_cycles.size();
    send(8'd1,   12'h001, 12'hAA1, 4'hA, 1'b1);
    send(8'd200, 12'h056, 12'hA56, 4'hB, 1'b1);
    drain();
    if (ov_cycles.size() == n_ov + 2) begin
      check("b2b_gap", 32'(ov_cycles[n_ov+1] - ov_cycles[n_ov]), 32'd10);
    end else begin
      check("b2b_pulse_count", 32'(ov_cycles.size() - n_ov), 32'd2);
    end

    // Outputs hold between conversions.
    repeat (5) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    check("hold_digits", 32'(digits), 32'h0A56);
`else
    check("hold_digits", 32'(digits), 32'h0056);
`endif
    check("hold_sign", 32'(sign_code), 32'hB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
